// File: rtl/div_unit_if.sv
// ============================================================================
//  Module   : div_unit_if
//  Brief    : Request/response bundle between the EX stage and the divider.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface div_unit_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] dividend;
   logic [XLEN-1:0] divisor;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, op, dividend, divisor, flush,
      input  busy, done, result
   );

   modport slave (
      input  start, op, dividend, divisor, flush,
      output busy, done, result
   );
endinterface

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
//  Module   : div_unit
//  Brief    : Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module div_unit #(
   parameter int XLEN = 32
) (
   input logic       clk,
   input logic       rst,
   div_unit_if.slave dbus
);

   localparam int         c_cnt_w   = $clog2(XLEN);
   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_calc = 2'd1;
   localparam logic [1:0] c_st_done = 2'd2;

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic [c_cnt_w-1:0] r_cnt;
   logic [XLEN-1:0]    r_rem;
   logic [XLEN-1:0]    r_quo;
   logic [XLEN-1:0]    r_dvs;
   logic [XLEN-1:0]    r_result;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_is_rem;

   logic               w_accept;
   logic               w_signed;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [XLEN-1:0]    w_a_abs;
   logic [XLEN-1:0]    w_b_abs;
   logic               w_div0;
   logic               w_ovf;
   logic               w_special;
   logic [XLEN-1:0]    w_special_val;
   logic [XLEN:0]      w_shift;
   logic [XLEN:0]      w_diff;
   logic               w_qbit;
   logic [XLEN-1:0]    w_rem_nxt;
   logic [XLEN-1:0]    w_quo_nxt;
   logic               w_last;
   logic [XLEN-1:0]    w_fin_q;
   logic [XLEN-1:0]    w_fin_r;

   // Operand conditioning at accept time
   always_comb begin
      w_accept  = (r_state == c_st_idle) && dbus.start && !dbus.flush;
      w_signed  = ~dbus.op[0];
      w_a_neg   = w_signed & dbus.dividend[XLEN-1];
      w_b_neg   = w_signed & dbus.divisor[XLEN-1];
      w_a_abs   = w_a_neg ? -dbus.dividend : dbus.dividend;
      w_b_abs   = w_b_neg ? -dbus.divisor  : dbus.divisor;
      w_div0    = (dbus.divisor == '0);
      w_ovf     = w_signed
                  && (dbus.dividend == {1'b1, {(XLEN-1){1'b0}}})
                  && (dbus.divisor == '1);
      w_special = w_div0 | w_ovf;
      if (w_div0)
         w_special_val = dbus.op[1] ? dbus.dividend : '1;
      else
         w_special_val = dbus.op[1] ? '0 : dbus.dividend;
   end

   // One restoring step; the quotient shifts in where dividend bits shift out
   always_comb begin
      w_shift   = {r_rem, r_quo[XLEN-1]};
      w_diff    = w_shift - {1'b0, r_dvs};
      w_qbit    = ~w_diff[XLEN];
      w_rem_nxt = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      w_quo_nxt = {r_quo[XLEN-2:0], w_qbit};
      w_last    = (r_cnt == c_cnt_w'(XLEN-1));
      w_fin_q   = r_neg_q ? -w_quo_nxt : w_quo_nxt;
      w_fin_r   = r_neg_r ? -w_rem_nxt : w_rem_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= c_st_idle;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: begin
            if (w_accept)
               w_state_nxt = w_special ? c_st_done : c_st_calc;
         end
         c_st_calc: begin
            if (dbus.flush)
               w_state_nxt = c_st_idle;
            else if (w_last)
               w_state_nxt = c_st_done;
         end
         c_st_done: w_state_nxt = c_st_idle;
         default:   w_state_nxt = c_st_idle;
      endcase
   end

   always_comb begin
      dbus.busy   = (r_state == c_st_calc);
      dbus.done   = (r_state == c_st_done);
      dbus.result = r_result;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_dvs    <= '0;
         r_result <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_is_rem <= 1'b0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (w_accept) begin
                  r_cnt    <= '0;
                  r_rem    <= '0;
                  r_quo    <= w_a_abs;
                  r_dvs    <= w_b_abs;
                  r_neg_q  <= w_a_neg ^ w_b_neg;
                  r_neg_r  <= w_a_neg;
                  r_is_rem <= dbus.op[1];
                  if (w_special)
                     r_result <= w_special_val;
               end
            end
            c_st_calc: begin
               if (!dbus.flush) begin
                  r_rem <= w_rem_nxt;
                  r_quo <= w_quo_nxt;
                  r_cnt <= r_cnt + c_cnt_w'(1);
                  if (w_last)
                     r_result <= r_is_rem ? w_fin_r : w_fin_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
//  Module   : tb_div_unit
//  Brief    : Directed self-checking bench for div_unit against a reference model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_div_unit;
   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   div_unit_if #(.XLEN(XLEN)) dbus ();
   div_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .dbus(dbus));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   // Model expectations, expressed in edge numbers
   int          m_busy_from = -1;
   int          m_busy_to   = -2;
   int          m_done_cyc  = -1;
   int          m_rst_cyc   = -1;
   logic [31:0] m_pend      = '0;
   logic [31:0] m_result    = '0;
   bit          chk_en      = 1'b0;
   int          t_acc       = 0;

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      bit                 ovf;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (o)
         2'b00:   return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
         2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         2'b10:   return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         logic exp_busy;
         logic exp_done;
         if (cyc == m_rst_cyc) m_result = '0;
         if (cyc == m_done_cyc) m_result = m_pend;
         exp_busy = (cyc >= m_busy_from) && (cyc <= m_busy_to);
         exp_done = (cyc == m_done_cyc);
         check32("busy",   {31'b0, dbus.busy}, {31'b0, exp_busy});
         check32("done",   {31'b0, dbus.done}, {31'b0, exp_done});
         check32("result", dbus.result, m_result);
      end
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
      bit sp;
      @(posedge clk);
      #1;
      dbus.start    = 1'b1;
      dbus.op       = o;
      dbus.dividend = a;
      dbus.divisor  = b;
      t_acc  = cyc + 1;
      sp     = (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      m_pend = model(o, a, b);
      m_done_cyc = sp ? t_acc : t_acc + 32;
      if (!sp) begin
         m_busy_from = t_acc;
         m_busy_to   = t_acc + 31;
      end
      repeat (hold) @(posedge clk);
      #1 dbus.start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input logic [31:0] lit, input int lat);
      int n    = 0;
      bit seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (dbus.done) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL %s: done never asserted, required within 40 cycles", nm);
      end else begin
         check32({nm, "_latency"}, 32'(cyc - t_acc), 32'(lat));
         check32(nm, dbus.result, lit);
      end
   endtask

   task automatic poke(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk);
      #1;
      dbus.start    = 1'b1;
      dbus.op       = o;
      dbus.dividend = a;
      dbus.divisor  = b;
      @(posedge clk);
      #1 dbus.start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int edge_n;
      rst           = 1'b1;
      dbus.start    = 1'b0;
      dbus.flush    = 1'b0;
      dbus.op       = 2'b00;
      dbus.dividend = '0;
      dbus.divisor  = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      check32("reset_busy",   {31'b0, dbus.busy}, 32'h0);
      check32("reset_done",   {31'b0, dbus.done}, 32'h0);
      check32("reset_result", dbus.result, 32'h0);

      issue(2'b00, 32'd100, 32'hFFFF_FFF9, 1);  wait_done("div_100_m7",   32'hFFFF_FFF2, 32);
      issue(2'b10, 32'd100, 32'hFFFF_FFF9, 1);  wait_done("rem_100_m7",   32'h0000_0002, 32);
      issue(2'b01, 32'hFFFF_FFFF, 32'd2, 1);    wait_done("divu_max_2",   32'h7FFF_FFFF, 32);
      issue(2'b10, 32'hFFFF_FF9C, 32'd7, 1);    wait_done("rem_m100_7",   32'hFFFF_FFFE, 32);
      issue(2'b11, 32'hFFFF_FF9C, 32'd7, 1);    wait_done("remu_m100_7",  32'h0000_0002, 32);
      issue(2'b01, 32'd5, 32'd0, 1);            wait_done("divu_5_0",     32'hFFFF_FFFF, 0);
      issue(2'b11, 32'd5, 32'd0, 1);            wait_done("remu_5_0",     32'h0000_0005, 0);
      issue(2'b00, 32'hFFFF_FFFB, 32'd0, 1);    wait_done("div_m5_0",     32'hFFFF_FFFF, 0);
      issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1); wait_done("div_ovf", 32'h8000_0000, 0);
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1); wait_done("rem_ovf", 32'h0000_0000, 0);

      // start held through DONE must not be taken as a second request
      issue(2'b01, 32'd9, 32'd0, 2);
      @(negedge clk);
      check32("start_in_done_busy", {31'b0, dbus.busy}, 32'h0);
      check32("start_in_done_result", dbus.result, 32'hFFFF_FFFF);

      // start together with flush in IDLE is refused
      @(posedge clk);
      #1;
      dbus.start = 1'b1; dbus.flush = 1'b1;
      dbus.op = 2'b01; dbus.dividend = 32'd50; dbus.divisor = 32'd7;
      @(posedge clk);
      #1;
      dbus.start = 1'b0; dbus.flush = 1'b0;
      repeat (3) @(negedge clk);
      check32("start_flush_idle_busy", {31'b0, dbus.busy}, 32'h0);

      // flush at iteration 10
      issue(2'b01, 32'd1000, 32'd3, 1);
      repeat (9) @(posedge clk);
      #1 dbus.flush = 1'b1;
      edge_n      = cyc + 1;
      m_busy_to   = edge_n - 1;
      m_done_cyc  = -1;
      @(posedge clk);
      #1 dbus.flush = 1'b0;
      @(negedge clk);
      check32("flush_busy", {31'b0, dbus.busy}, 32'h0);
      repeat (40) @(negedge clk);
      check32("flush_result_held", dbus.result, 32'hFFFF_FFFF);
      issue(2'b01, 32'd50, 32'd7, 1);            wait_done("divu_50_7", 32'h0000_0007, 32);

      // start pulses while busy must not disturb the running op
      issue(2'b00, 32'd100, 32'hFFFF_FFF9, 1);
      for (int i = 0; i < 5; i++)
         poke(2'(i), $urandom, $urandom_range(1, 1000));
      wait_done("div_busy_start", 32'hFFFF_FFF2, 32);

      // reset in the middle of CALC
      issue(2'b01, 32'hFFFF_FFFF, 32'd3, 1);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      edge_n     = cyc + 1;
      m_busy_to  = edge_n - 1;
      m_done_cyc = -1;
      m_rst_cyc  = edge_n;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check32("rst_mid_busy",   {31'b0, dbus.busy}, 32'h0);
      check32("rst_mid_done",   {31'b0, dbus.done}, 32'h0);
      check32("rst_mid_result", dbus.result, 32'h0);
      repeat (40) @(negedge clk);
      issue(2'b01, 32'hFFFF_FFFF, 32'd3, 1);     wait_done("divu_after_rst", 32'h5555_5555, 32);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the EX stage beside the combinational ALU, which covers ADD..MULHU.
- The EX stage steers divide ops here and stalls the pipeline from start until done.
- Its result is muxed with the ALU output into the EX/MEM register.

Parameters:
XLEN, 32, operand/result width in bits; iteration count equals XLEN.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request; accepted only when the FSM is in IDLE
op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; captured on accept
dividend  input  XLEN  rs1 value; captured on accept
divisor  input  XLEN  rs2 value; captured on accept
flush  input  1  pipeline flush; aborts any operation in progress
busy  output  1  high while the FSM is in CALC
done  output  1  one-cycle pulse; result valid in that cycle
result  output  XLEN  quotient or remainder; held until the next done

Behaviour:
- One clock (clk); reset (rst) is synchronous and active-high.
- Reset: FSM to IDLE, busy=0, done=0, result=0, internal registers cleared. Reset mid-CALC aborts with no done pulse.
- States:
  - IDLE: start=1 and flush=0 → capture op/operands. Special case → DONE; otherwise → CALC with iteration counter=0.
  - CALC: one quotient bit per cycle, MSB first. Partial remainder is XLEN+1 bits: shift left, subtract |divisor|, restore if negative. After XLEN iterations (counter==XLEN-1) → DONE.
  - DONE: done=1 and result driven from the final value; unconditionally → IDLE next cycle. start during DONE is ignored.
- Latency: start sampled at edge T → CALC during T+1..T+XLEN → done during cycle T+XLEN+1 (33 cycles for XLEN=32). Special cases: done during T+1.
- Signed ops (DIV, REM):
  - Divide the absolute values; INT_MIN magnitude is handled as an unsigned 2^31.
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the dividend's sign.
- Unsigned ops use the operands as-is.
- Special cases, decided at accept with no iteration:
  - divisor==0: DIV/DIVU → all ones; REM/REMU → dividend.
  - DIV with dividend=0x80000000, divisor=0xFFFFFFFF: quotient 0x80000000; REM of the same operands → 0.
- Flush:
  - In CALC: → IDLE next edge, busy=0, no done, result unchanged.
  - In DONE: done still asserts that cycle; the consumer discards it.
  - start and flush together in IDLE: not accepted.
- start while busy: ignored; operands are not re-captured.
- result changes only on entry to DONE and is stable at all other times.

Test Plan:
- DIV 100 / 0xFFFFFFF9 (-7) → done 33 cycles after start, result 0xFFFFFFF2. REM on the same operands → 0x00000002.
- DIVU 0xFFFFFFFF / 2 → 0x7FFFFFFF. REM 0xFFFFFF9C (-100) / 7 → 0xFFFFFFFE. REMU 0xFFFFFF9C / 7 → 0x00000002.
- Divide by zero, DIVU 5/0 → 0xFFFFFFFF with done one cycle after start; REMU 5/0 → 5; DIV 0xFFFFFFFB/0 → 0xFFFFFFFF.
- Overflow, DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 one cycle after start; REM on the same operands → 0.
- Flush at CALC iteration 10 → busy low next cycle, no done, result keeps its prior value. A following DIVU 50/7 → 7 with normal latency.
- start pulsed repeatedly while busy with different operands → the original op completes unchanged. rst asserted mid-CALC → busy=0, done=0, result=0 next cycle.
